// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: takes target angles over valid/ready and slews the PWM
// angle toward them by at most STEP degrees per servo frame.
// Ports: clk, rst_n (async active-low)
//        cmd_valid, cmd_angle[7:0], cmd_ready : target command handshake
//        angle[7:0] : current angle, to PWM block
//        busy       : moving toward target
//        done       : one-cycle pulse when target reached
//        frame_tick : one-cycle pulse on last cycle of each frame
module servo_slew_ctrl #(
   parameter int FRAME_CYCLES = 2_000_000,
   parameter int STEP         = 5,
   parameter int MAX_ANGLE    = 180,
   parameter int HOME_ANGLE   = 90
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_angle,
   output logic       cmd_ready,
   output logic [7:0] angle,
   output logic       busy,
   output logic       done,
   output logic       frame_tick
);

   localparam int CW = $clog2(FRAME_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] PRE  = CW'(FRAME_CYCLES - 2);
   localparam logic [7:0]    MAXA = 8'(MAX_ANGLE);
   localparam logic [7:0]    HOME = 8'(HOME_ANGLE);
   localparam logic [7:0]    STP8 = 8'(STEP);
   localparam logic [8:0]    STP9 = 9'(STEP);

   typedef enum logic {IDLE, MOVING} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    target;
   logic [7:0]    clamped;
   logic [8:0]    diff;
   logic          up;

   assign clamped   = (cmd_angle > MAXA) ? MAXA : cmd_angle;
   assign up        = (target > angle);
   // 9-bit difference so a large gap can never wrap
   assign diff      = up ? ({1'b0, target} - {1'b0, angle})
                         : ({1'b0, angle} - {1'b0, target});
   assign cmd_ready = (state == IDLE);
   assign busy      = (state == MOVING);

   // free-running frame counter; tick is registered one count early
   // so it is high exactly while cnt == LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         frame_tick <= 1'b0;
      end else begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CW'(1);
         frame_tick <= (cnt == PRE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         target <= HOME;
         angle  <= HOME;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  target <= clamped;
                  if (clamped == angle) done  <= 1'b1;
                  else                  state <= MOVING;
               end
            end
            MOVING: begin
               if (frame_tick) begin
                  if (diff <= STP9) begin
                     angle <= target;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else if (up) begin
                     angle <= angle + STP8;
                  end else begin
                     angle <= angle - STP8;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb_servo_slew_ctrl: directed and random target commands checked
// against a per-move arithmetic model of the slew profile.
module tb_servo_slew_ctrl;

   localparam int FC   = 100;
   localparam int STEP = 5;
   localparam int MAXA = 180;
   localparam int HOME = 90;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [7:0] cmd_angle;
   logic       cmd_ready;
   logic [7:0] angle;
   logic       busy;
   logic       done;
   logic       frame_tick;

   int tests = 0;
   int fails = 0;
   int model_angle = HOME;

   servo_slew_ctrl #(
      .FRAME_CYCLES(FC),
      .STEP(STEP),
      .MAX_ANGLE(MAXA),
      .HOME_ANGLE(HOME)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_angle(cmd_angle),
      .cmd_ready(cmd_ready),
      .angle(angle),
      .busy(busy),
      .done(done),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // model: position after k frame ticks of a move from s toward t
   function automatic int exp_pos(input int s, input int t, input int k);
      int d, m;
      d = (t > s) ? t - s : s - t;
      m = (STEP * k < d) ? STEP * k : d;
      return (t > s) ? s + m : s - m;
   endfunction

   task automatic send(input int v);
      for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
      chk("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_angle = 8'(v);
      @(posedge clk);
   endtask

   task automatic do_move(input int v);
      int s, t, d, n, k, lim;
      bit fin;
      s = model_angle;
      t = (v > MAXA) ? MAXA : v;
      d = (t > s) ? t - s : s - t;
      n = (d + STEP - 1) / STEP;
      send(v);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (d == 0) begin
         chk("same_done", int'(done), 1);
         chk("same_busy", int'(busy), 0);
         chk("same_ready", int'(cmd_ready), 1);
         chk("same_angle", int'(angle), s);
      end else begin
         chk("accept_busy", int'(busy), 1);
         chk("accept_ready", int'(cmd_ready), 0);
         k = 0;
         fin = 0;
         lim = FC * (n + 2);
         for (int c = 0; c < lim && !fin; c++) begin
            chk("angle", int'(angle), exp_pos(s, t, k));
            chk("range", int'(angle <= 8'(MAXA)), 1);
            if (k == n) begin
               chk("arrive_done", int'(done), 1);
               chk("arrive_busy", int'(busy), 0);
               chk("arrive_ready", int'(cmd_ready), 1);
               cmd_valid = 1'b0;
               fin = 1;
            end else begin
               chk("move_busy", int'(busy), 1);
               chk("move_done", int'(done), 0);
               if (frame_tick) k++;
               // stray commands while moving must be ignored
               cmd_valid = ($urandom_range(0, 7) == 0);
               cmd_angle = 8'($urandom_range(0, 255));
               @(negedge clk);
            end
         end
         if (!fin) chk("move_timeout", k, n);
      end
      @(negedge clk);
      chk("done_pulse_end", int'(done), 0);
      model_angle = t;
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_angle = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (37) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_angle", int'(angle), HOME);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tick", int'(frame_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 3 * FC && n == 0; i++) begin
         @(negedge clk);
         if (frame_tick) n = i;
      end
      chk("first_tick_cycle", n, FC - 1);
      model_angle = HOME;

      do_move(100);
      do_move(90);
      do_move(0);
      do_move(3);
      do_move(250);
      do_move(180);
      do_move(90);
      do_move(90);

      send(180);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 10 * FC && angle != 8'd120; i++)
         @(negedge clk);
      chk("t6_reach", int'(angle), 120);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_angle", int'(angle), HOME);
      chk("t6_ready", int'(cmd_ready), 1);
      chk("t6_busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_angle = HOME;
      do_move(95);

      for (int r = 0; r < 8; r++)
         do_move(int'($urandom_range(0, 255)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
